alu_basic: RTL and testbench

- Hack-style 16-bit ALU, stage 1: six control bits select one of 18 canonical functions of x and y. No zr/ng status flags.
- Result is registered: one-cycle latency with a valid strobe.
- Sits in the Boolean-arithmetic layer and feeds the later flagged ALU and CPU datapath.

---
 rtl/alu_basic_if.sv | 28 ++
 rtl/alu_basic.sv | 93 +++++++++
 tb/tb_alu_basic.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_basic_if.sv
// alu_basic_if: operand/control/result bundle for the Hack-style stage-1 ALU.
//   master : drives x, y, zx, nx, zy, ny, f, no, in_valid; observes out, out_valid
//   slave  : the ALU; consumes operands/controls, returns registered out/out_valid
interface alu_basic_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx;
    logic             nx;
    logic             zy;
    logic             ny;
    logic             f;
    logic             no;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (
        output x, y, zx, nx, zy, ny, f, no, in_valid,
        input  out, out_valid
    );

    modport slave (
        input  x, y, zx, nx, zy, ny, f, no, in_valid,
        output out, out_valid
    );
endinterface

// File: rtl/alu_basic.sv
// alu_basic: Hack-style WIDTH-bit ALU (no status flags) with a registered result.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears out and out_valid)
//   bus   : alu_basic_if slave modport
//           x, y            operands
//           zx/nx, zy/ny    zero then negate x / y
//           f               1 = add, 0 = bitwise AND
//           no              negate the result
//           in_valid        capture this cycle's result
//           out, out_valid  result registered one edge after capture; valid for one cycle
module alu_basic #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_basic_if.slave   bus
);

    logic [WIDTH-1:0] x1_s;
    logic [WIDTH-1:0] x2_s;
    logic [WIDTH-1:0] y1_s;
    logic [WIDTH-1:0] y2_s;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] res_s;
    logic [WIDTH-1:0] out_r;
    logic             out_valid_r;

    // x operand conditioning: zero first, then bitwise negate
    always_comb begin
        x1_s = {WIDTH{1'b0}};
        x2_s = {WIDTH{1'b0}};
        if (bus.zx) begin
            x1_s = {WIDTH{1'b0}};
        end else begin
            x1_s = bus.x;
        end
        if (bus.nx) begin
            x2_s = ~x1_s;
        end else begin
            x2_s = x1_s;
        end
    end

    // y operand conditioning: zero first, then bitwise negate
    always_comb begin
        y1_s = {WIDTH{1'b0}};
        y2_s = {WIDTH{1'b0}};
        if (bus.zy) begin
            y1_s = {WIDTH{1'b0}};
        end else begin
            y1_s = bus.y;
        end
        if (bus.ny) begin
            y2_s = ~y1_s;
        end else begin
            y2_s = y1_s;
        end
    end

    // function select and optional output negation; the sum wraps (carry dropped)
    always_comb begin
        r_s   = {WIDTH{1'b0}};
        res_s = {WIDTH{1'b0}};
        if (bus.f) begin
            r_s = x2_s + y2_s;
        end else begin
            r_s = x2_s & y2_s;
        end
        if (bus.no) begin
            res_s = ~r_s;
        end else begin
            res_s = r_s;
        end
    end

    // result register: load on in_valid, otherwise hold data and drop the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else if (bus.in_valid) begin
            out_r       <= res_s;
            out_valid_r <= 1'b1;
        end else begin
            out_r       <= out_r;
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_alu_basic.sv
// tb_alu_basic: scoreboard bench for alu_basic (WIDTH = 16).
module tb_alu_basic;

    localparam int W = 16;

    // canonical codes {zx,nx,zy,ny,f,no} and their results for x = 000A, y = 0003
    localparam logic [5:0] CODES [18] = '{
        6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
        6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
        6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
    };
    localparam logic [15:0] EXPS [18] = '{
        16'h0000, 16'h0001, 16'hFFFF, 16'h000A, 16'h0003, 16'hFFF5,
        16'hFFFC, 16'hFFF6, 16'hFFFD, 16'h000B, 16'h0004, 16'h0009,
        16'h0002, 16'h000D, 16'h0007, 16'hFFF9, 16'h0002, 16'h000B
    };

    logic clk;
    logic rst_n;

    alu_basic_if #(.WIDTH(W)) bus ();

    alu_basic #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          err_cnt;
    int          chk_cnt;
    logic [15:0] exp_q [$];
    logic [15:0] last_out;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // independent reference of the ALU equations
    function automatic logic [15:0] ref_alu(input logic [15:0] xv, input logic [15:0] yv,
                                            input logic [5:0] c);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        a = c[5] ? 16'h0000 : xv;
        if (c[4]) a = a ^ 16'hFFFF;
        b = c[3] ? 16'h0000 : yv;
        if (c[2]) b = b ^ 16'hFFFF;
        r = c[1] ? 16'((32'(a) + 32'(b)) % 32'h10000) : (a & b);
        if (c[0]) r = r ^ 16'hFFFF;
        return r;
    endfunction

    // drive at negedge, push expectation, then check one step after the next posedge
    task automatic step(input string tag, input logic v, input logic [5:0] c,
                        input logic [15:0] xv, input logic [15:0] yv, input logic [15:0] expv);
        logic [15:0] e;
        @(negedge clk);
        bus.in_valid = v;
        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = c;
        bus.x = xv;
        bus.y = yv;
        if (v) exp_q.push_back(expv);
        @(posedge clk);
        #1;
        check_eq({tag, "_vld"}, {15'd0, bus.out_valid}, {15'd0, v});
        if (v) begin
            if (exp_q.size() == 0) begin
                check_eq({tag, "_empty_q"}, 16'd1, 16'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq(tag, bus.out, e);
                last_out = e;
            end
        end else begin
            check_eq({tag, "_hold"}, bus.out, last_out);
        end
    endtask

    initial begin
        logic [15:0] rx;
        logic [15:0] ry;
        logic [5:0]  rc;
        logic        rv;
        err_cnt      = 0;
        chk_cnt      = 0;
        last_out     = 16'h0000;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'b000000;
        bus.x        = 16'h0000;
        bus.y        = 16'h0000;

        #2;
        check_eq("rst_out", bus.out, 16'h0000);
        check_eq("rst_vld", {15'd0, bus.out_valid}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // capture something, then assert reset asynchronously mid-cycle
        step("pre_rst", 1'b1, 6'b000010, 16'h000A, 16'h0003, 16'h000D);
        @(negedge clk);
        bus.in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_out", bus.out, 16'h0000);
        check_eq("async_rst_vld", {15'd0, bus.out_valid}, 16'h0000);
        @(posedge clk);
        #1;
        check_eq("rst_edge_out", bus.out, 16'h0000);
        check_eq("rst_edge_vld", {15'd0, bus.out_valid}, 16'h0000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        last_out = 16'h0000;
        @(posedge clk);
        #1;
        check_eq("post_rst_vld", {15'd0, bus.out_valid}, 16'h0000);
        check_eq("post_rst_out", bus.out, 16'h0000);

        // all 18 canonical codes, back to back
        for (int i = 0; i < 18; i++) begin
            step($sformatf("canon%0d", i), 1'b1, CODES[i], 16'h000A, 16'h0003, EXPS[i]);
        end

        // wrap-around corners
        step("wrap_xpy", 1'b1, 6'b000010, 16'hFFFF, 16'h0001, 16'h0000);
        step("neg_min",  1'b1, 6'b001111, 16'h8000, 16'h1234, 16'h8000);
        step("xm1_zero", 1'b1, 6'b001110, 16'h0000, 16'h5555, 16'hFFFF);

        // hold: capture then idle with changing inputs
        step("hold_cap", 1'b1, 6'b000010, 16'h000A, 16'h0003, 16'h000D);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("hold%0d", i), 1'b0, 6'($urandom_range(0, 63)),
                 16'($urandom), 16'($urandom), 16'h0000);
        end

        // random traffic
        for (int i = 0; i < 1000; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rc = 6'($urandom_range(0, 63));
            rv = 1'($urandom_range(0, 1));
            step("rand", rv, rc, rx, ry, ref_alu(rx, ry, rc));
        end

        check_eq("q_drained", 16'(exp_q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
